// File: rtl/fft_stream_ctrl.sv
// Streams N samples into an FFT core, waits for its completion strobe, then
// replays the captured result bus as an N-word valid/ready stream.
module fft_stream_ctrl #(
   parameter int N       = 16,
   parameter int MSB     = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   input  logic [MSB-1:0]       s_data,
   output logic                 s_ready,
   output logic                 m_valid,
   output logic [MSB-1:0]       m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic [MSB-1:0]       fft_data_in,
   output logic [$clog2(N)-1:0] fft_addr,
   output logic                 fft_insert_data,
   input  logic [MSB*N-1:0]     fft_data_out,
   input  logic                 fft_finish,
   output logic                 busy,
   output logic                 err,
   output logic                 frame_done
);
   localparam int AW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, UNLOAD} state_t;

   state_t         state_q;
   logic [AW-1:0]  cnt_q, cnt_d, idx_q, idx_d, addr_q;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [MSB-1:0] mem_q [N];
   logic [MSB-1:0] m_data_q, din_q;
   logic           s_ready_q, m_valid_q, m_last_q, ins_q, busy_q, err_q, fd_q;
   logic           s_acc, m_acc;

   assign s_acc = s_valid && s_ready_q;
   assign m_acc = m_valid_q && m_ready;
   assign cnt_d = cnt_q + AW'(1);
   assign idx_d = idx_q + AW'(1);
   assign tmo_d = tmo_q + TW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         for (int k = 0; k < N; k++) mem_q[k] <= '0;
         m_data_q  <= '0;
         din_q     <= '0;
         addr_q    <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         ins_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         fd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               s_ready_q <= 1'b1;
               ins_q     <= 1'b0;
               if (s_acc) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  din_q   <= s_data;
                  addr_q  <= '0;
                  ins_q   <= 1'b1;
                  cnt_q   <= AW'(1);
               end
            end
            // Without an accepted beat the load outputs simply hold.
            LOAD: begin
               if (s_acc) begin
                  din_q  <= s_data;
                  addr_q <= cnt_q;
                  ins_q  <= 1'b1;
                  if (cnt_q == AW'(N - 1)) begin
                     state_q   <= WAIT;
                     s_ready_q <= 1'b0;
                     cnt_q     <= '0;
                     tmo_q     <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            WAIT: begin
               ins_q <= 1'b0;
               if (fft_finish) begin
                  for (int k = 0; k < N; k++) mem_q[k] <= fft_data_out[MSB*k +: MSB];
                  m_data_q  <= fft_data_out[MSB-1:0];
                  m_last_q  <= 1'b0;
                  m_valid_q <= 1'b1;
                  idx_q     <= '0;
                  state_q   <= UNLOAD;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  err_q     <= 1'b1;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  s_ready_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            UNLOAD: begin
               if (m_acc) begin
                  if (idx_q == AW'(N - 1)) begin
                     state_q   <= IDLE;
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     fd_q      <= 1'b1;
                     busy_q    <= 1'b0;
                     s_ready_q <= 1'b1;
                     idx_q     <= '0;
                  end else begin
                     idx_q    <= idx_d;
                     m_data_q <= mem_q[idx_d];
                     m_last_q <= (idx_d == AW'(N - 1));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_ready         = s_ready_q;
   assign m_valid         = m_valid_q;
   assign m_data          = m_data_q;
   assign m_last          = m_last_q;
   assign fft_data_in     = din_q;
   assign fft_addr        = addr_q;
   assign fft_insert_data = ins_q;
   assign busy            = busy_q;
   assign err             = err_q;
   assign frame_done      = fd_q;
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Scoreboard bench for fft_stream_ctrl: directed frames push expected load writes
// and output words into queues; a negedge monitor pops and compares.
module tb_fft_stream_ctrl;
   localparam int N = 16;
   localparam int MSB = 16;
   localparam int TIMEOUT = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic [15:0]  s_data = '0;
   logic         s_ready;
   logic         m_valid;
   logic [15:0]  m_data;
   logic         m_last;
   logic         m_ready = 1'b1;
   logic [15:0]  fft_data_in;
   logic [3:0]   fft_addr;
   logic         fft_insert_data;
   logic [255:0] fft_data_out = '0;
   logic         fft_finish = 1'b0;
   logic         busy, err, frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fft_stream_ctrl #(.N(N), .MSB(MSB), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .fft_data_in(fft_data_in), .fft_addr(fft_addr), .fft_insert_data(fft_insert_data),
      .fft_data_out(fft_data_out), .fft_finish(fft_finish),
      .busy(busy), .err(err), .frame_done(frame_done)
   );

   typedef struct packed {logic [3:0] addr; logic [15:0] data;} ld_t;
   typedef struct packed {logic [15:0] data; logic last;} out_t;
   ld_t  ld_q[$];
   out_t out_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got an event with no expectation queued", name);
   endtask

   bit          acc_prev = 0, ld_act = 0, hs_last_prev = 0, stall_prev = 0;
   logic [15:0] hold_data = '0;
   logic        hold_last = 1'b0;
   ld_t         last_ld = '0;
   int          ld_cnt = 0, out_cnt = 0, fd_cnt = 0, ins_cyc = 0;

   always @(negedge clk) begin : mon
      ld_t  e;
      out_t o;
      if (rst) begin
         acc_prev = 0; ld_act = 0; hs_last_prev = 0; stall_prev = 0;
      end else begin
         if (acc_prev) begin
            if (ld_q.size() == 0) miss("ld_write");
            else begin
               e = ld_q.pop_front();
               chk("ld_addr", 32'(fft_addr), 32'(e.addr));
               chk("ld_data", 32'(fft_data_in), 32'(e.data));
               chk("ld_insert", 32'(fft_insert_data), 32'd1);
               last_ld = e;
               ld_act  = (e.addr != 4'd15);
            end
            ld_cnt++;
         end else if (ld_act) begin
            chk("hold_addr", 32'(fft_addr), 32'(last_ld.addr));
            chk("hold_data", 32'(fft_data_in), 32'(last_ld.data));
            chk("hold_insert", 32'(fft_insert_data), 32'd1);
         end
         chk("frame_done", 32'(frame_done), 32'(hs_last_prev));
         if (hs_last_prev) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("m_valid_at_done", 32'(m_valid), 32'd0);
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(hold_data));
            chk("stall_last", 32'(m_last), 32'(hold_last));
         end
         if (frame_done) fd_cnt++;
         if (fft_insert_data) ins_cyc++;
         acc_prev     = s_valid && s_ready;
         hs_last_prev = 0;
         stall_prev   = m_valid && !m_ready;
         hold_data    = m_data;
         hold_last    = m_last;
         if (m_valid && m_ready) begin
            if (out_q.size() == 0) miss("out_word");
            else begin
               o = out_q.pop_front();
               chk("m_data", 32'(m_data), 32'(o.data));
               chk("m_last", 32'(m_last), 32'(o.last));
               hs_last_prev = o.last;
            end
            out_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_fft_data_in", 32'(fft_data_in), 32'd0);
      chk("rst_fft_addr", 32'(fft_addr), 32'd0);
      chk("rst_insert", 32'(fft_insert_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
   endtask

   // Release reset and confirm s_ready rises after the first clean edge.
   task automatic release_reset();
      tick();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("s_ready_after_rst", 32'(s_ready), 32'd1);
      chk("busy_after_rst", 32'(busy), 32'd0);
      tick();
   endtask

   task automatic send_frame(input logic [15:0] base, input int gap, input int spur_k);
      ld_t e;
      int  t;
      for (int k = 0; k < N; k++) begin
         s_valid = 1'b1;
         s_data  = base + 16'(k);
         e.addr  = 4'(k);
         e.data  = base + 16'(k);
         ld_q.push_back(e);
         if (k == spur_k) begin
            fft_finish   = 1'b1;
            fft_data_out = {16{16'hBAD0}};
         end
         t = 0;
         @(negedge clk);
         while (!s_ready && t < 50) begin
            t++;
            @(negedge clk);
         end
         if (!s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL s_ready_wait: got 0 want 1");
         end
         tick();
         s_valid    = 1'b0;
         fft_finish = 1'b0;
         if (k != N - 1) repeat (gap) tick();
      end
   endtask

   task automatic finish_after(input int d, input logic [15:0] base);
      out_t o;
      repeat (d - 1) tick();
      for (int k = 0; k < N; k++) begin
         fft_data_out[16*k +: 16] = base + 16'(k);
         o.data = base + 16'(k);
         o.last = (k == N - 1);
         out_q.push_back(o);
      end
      fft_finish = 1'b1;
      tick();
      fft_finish   = 1'b0;
      fft_data_out = {16{16'hDEAD}};
   endtask

   task automatic wait_done(input int fd0, input bit toggle);
      int t;
      t = 0;
      while (fd_cnt == fd0 && t < 200) begin
         if (toggle) m_ready = ~m_ready;
         tick();
         t++;
      end
      chk("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
      m_ready = 1'b1;
   endtask

   task automatic run_frame(input logic [15:0] sbase, input int gap, input int spur,
                            input logic [15:0] obase, input bit toggle);
      int l0, o0, i0, f0;
      l0 = ld_cnt; o0 = out_cnt; i0 = ins_cyc; f0 = fd_cnt;
      send_frame(sbase, gap, spur);
      finish_after(5, obase);
      wait_done(f0, toggle);
      tick();
      chk("ld_writes", 32'(ld_cnt - l0), 32'(N));
      chk("out_words", 32'(out_cnt - o0), 32'(N));
      chk("insert_cycles", 32'(ins_cyc - i0), 32'(N + gap * (N - 1)));
      chk("out_q_empty", 32'(out_q.size()), 32'd0);
      chk("ld_q_empty", 32'(ld_q.size()), 32'd0);
   endtask

   initial begin : stim
      int o0, t;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      release_reset();

      // nominal, stalled input, output backpressure
      run_frame(16'd1, 0, -1, 16'd100, 1'b0);
      chk("err_nominal", 32'(err), 32'd0);
      run_frame(16'h0040, 2, -1, 16'd200, 1'b0);
      run_frame(16'h0050, 0, -1, 16'd300, 1'b1);

      // timeout: no fft_finish in WAIT
      send_frame(16'h0060, 0, -1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("err_before_timeout", 32'(err), 32'd0);
      chk("busy_in_wait", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("err_at_timeout", 32'(err), 32'd1);
      chk("busy_after_timeout", 32'(busy), 32'd0);
      chk("s_ready_after_timeout", 32'(s_ready), 32'd1);
      chk("m_valid_after_timeout", 32'(m_valid), 32'd0);
      tick();
      run_frame(16'h0070, 0, -1, 16'd400, 1'b0);
      chk("err_sticky", 32'(err), 32'd1);

      // spurious fft_finish during LOAD
      run_frame(16'h0080, 0, 8, 16'h0A00, 1'b0);

      // reset after output word 5
      m_ready = 1'b0;
      send_frame(16'h0090, 0, -1);
      finish_after(5, 16'd700);
      o0 = out_cnt;
      m_ready = 1'b1;
      t = 0;
      while (out_cnt - o0 < 6 && t < 100) begin
         tick();
         t++;
      end
      chk("words_before_rst", 32'(out_cnt - o0), 32'd6);
      rst = 1'b1;
      m_ready = 1'b0;
      out_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      release_reset();
      m_ready = 1'b1;
      run_frame(16'h00A0, 0, -1, 16'd800, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end
endmodule
